// File: rtl/fdivsqrt_r2_seq.sv
// Radix-2 divide/sqrt sequencer: accepts an op, pulses the datapath load, runs N recurrence
// steps and holds the result valid until the consumer takes it.
module fdivsqrt_r2_seq #(
   parameter int unsigned CNTW = 7
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            Start,
   input  logic            SqrtE,
   input  logic            SpecialCaseE,
   input  logic [CNTW-1:0] NumIterE,
   input  logic            Flush,
   input  logic            ResultReady,
   output logic            Ready,
   output logic            Init,
   output logic            IterEn,
   output logic            LastIter,
   output logic            Busy,
   output logic            Valid,
   output logic            SqrtM,
   output logic            SpecialCaseM,
   output logic [CNTW-1:0] IterCnt
);

   // One-hot encoding; any illegal pattern decodes to no outputs and recovers to idle.
   typedef enum logic [2:0] {
      StIdle = 3'b001,
      StIter = 3'b010,
      StDone = 3'b100
   } state_e;

   state_e          state_q, state_d;
   logic [CNTW-1:0] iter_cnt_q, iter_cnt_d;
   logic            sqrt_q, sqrt_d;
   logic            special_q, special_d;

   logic            accept;
   logic            bypass;

   always_comb begin
      accept = Start & (state_q == StIdle) & ~Flush;
      bypass = SpecialCaseE | (NumIterE == '0);
   end

   always_comb begin
      state_d    = state_q;
      iter_cnt_d = iter_cnt_q;
      sqrt_d     = sqrt_q;
      special_d  = special_q;

      if (Flush) begin
         state_d    = StIdle;
         iter_cnt_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  sqrt_d    = SqrtE;
                  special_d = SpecialCaseE;
                  if (bypass) begin
                     state_d    = StDone;
                     iter_cnt_d = '0;
                  end else begin
                     state_d    = StIter;
                     iter_cnt_d = NumIterE;
                  end
               end
            end
            StIter: begin
               // A count of 1 is the final step; 0 cannot occur here but is treated the same
               // so the counter never wraps.
               if (iter_cnt_q > CNTW'(1)) begin
                  iter_cnt_d = iter_cnt_q - CNTW'(1);
               end else begin
                  state_d    = StDone;
                  iter_cnt_d = '0;
               end
            end
            StDone: begin
               if (ResultReady) begin
                  state_d = StIdle;
               end
            end
            default: begin
               state_d    = StIdle;
               iter_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         iter_cnt_q <= '0;
         sqrt_q     <= 1'b0;
         special_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         iter_cnt_q <= iter_cnt_d;
         sqrt_q     <= sqrt_d;
         special_q  <= special_d;
      end
   end

   always_comb begin
      Ready        = (state_q == StIdle);
      Init         = accept & ~bypass;
      IterEn       = (state_q == StIter);
      LastIter     = (state_q == StIter) & (iter_cnt_q == CNTW'(1));
      Busy         = (state_q == StIter) | (state_q == StDone);
      Valid        = (state_q == StDone);
      SqrtM        = sqrt_q;
      SpecialCaseM = special_q;
      IterCnt      = iter_cnt_q;
   end

endmodule
